// File: rtl/midi_pkg.sv
// MIDI receive path shared definitions: baud constant, real-time threshold,
// channel status nibbles and the receiver FSM state type.
package midi_pkg;

   localparam int         MIDI_BAUD   = 31250;
   localparam logic [7:0] MIDI_RT_MIN = 8'hF8;

   // Status nibbles (upper four bits of a status byte)
   localparam logic [3:0] NOTE_OFF         = 4'h8;
   localparam logic [3:0] NOTE_ON          = 4'h9;
   localparam logic [3:0] POLY_PRESSURE    = 4'hA;
   localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
   localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
   localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
   localparam logic [3:0] PITCH_BEND       = 4'hE;
   localparam logic [3:0] SYSTEM_MSG       = 4'hF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   // True for single-byte real-time messages (clock, start, stop, sensing, reset)
   function automatic logic is_realtime(input logic [7:0] b);
      return (b >= MIDI_RT_MIN);
   endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// Circular byte FIFO with occupancy count. A push while full is dropped
// unless a pop happens in the same cycle. dout reads 8'h00 while empty.
module midi_byte_fifo
   import midi_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_count == {CW{1'b0}});
   assign w_full    = (r_count == CW'(FIFO_DEPTH));
   assign w_do_pop  = pop && !w_empty;
   assign w_do_push = push && (!w_full || w_do_pop);

   // Storage write; contents need no reset because reads are gated by count
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr <= {PW{1'b0}};
         r_wr_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head byte presented to the consumer, forced to zero while empty
   always_comb begin
      dout = 8'h00;
      if (w_empty) begin
         dout = 8'h00;
      end else begin
         dout = r_mem[r_rd_ptr];
      end
   end

   assign empty = w_empty;
   assign full  = w_full;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver: 2-flop synchronizer, bit-timing FSM with start
// glitch rejection and break handling, byte FIFO, sticky overflow flag.
// Optional build macro MIDI_REALTIME_FILTER_EN drops real-time bytes
// (8'hF8..8'hFF) at the push point so they never reach the decoder.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1600,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] message,
   output logic       dataValid,
   input  logic       read,
   output logic       frameErr,
   output logic       overflow
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   logic          r_sync1;
   logic          r_sync2;
   rx_state_t     r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic          r_frame_err;
   logic          r_overflow;

   rx_state_t     w_state_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [2:0]    w_idx_nx;
   logic [7:0]    w_shift_nx;
   logic          w_stop_ok;
   logic          w_stop_bad;
   logic          w_rxs;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [7:0]    w_dout;

   assign w_rxs = r_sync2;

   // Two-flop synchronizer for the asynchronous serial line (idles high)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   // Receiver state, bit-timing counter, bit index and shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= {CW{1'b0}};
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
         r_shift <= w_shift_nx;
      end
   end

   // Next-state logic: mid-bit sampling, stop-bit validation, break wait
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_idx_nx   = r_idx;
      w_shift_nx = r_shift;
      w_stop_ok  = 1'b0;
      w_stop_bad = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nx = {CW{1'b0}};
            if (!w_rxs) begin
               w_state_nx = START;
            end else begin
               w_state_nx = IDLE;
            end
         end
         START: begin
            if (r_cnt == HALF_LAST) begin
               w_cnt_nx = {CW{1'b0}};
               if (!w_rxs) begin
                  w_state_nx = DATA;
                  w_idx_nx   = 3'd0;
               end else begin
                  // line went back high before mid-start: a glitch
                  w_state_nx = IDLE;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         DATA: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nx   = {CW{1'b0}};
               w_shift_nx = {w_rxs, r_shift[7:1]};
               if (r_idx == 3'd7) begin
                  w_state_nx = STOP;
               end else begin
                  w_idx_nx = r_idx + 3'd1;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         STOP: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nx = {CW{1'b0}};
               if (w_rxs) begin
                  w_stop_ok  = 1'b1;
                  w_state_nx = IDLE;
               end else begin
                  w_stop_bad = 1'b1;
                  w_state_nx = BREAK;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         BREAK: begin
            // hold here until the line idles so a long low gives one error
            w_cnt_nx = {CW{1'b0}};
            if (w_rxs) begin
               w_state_nx = IDLE;
            end else begin
               w_state_nx = BREAK;
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_cnt_nx   = {CW{1'b0}};
         end
      endcase
   end

`ifdef MIDI_REALTIME_FILTER_EN
   assign w_push = w_stop_ok && !is_realtime(r_shift);
`else
   assign w_push = w_stop_ok;
`endif

   assign w_pop = read && !w_empty;

   midi_byte_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (w_push),
      .din  (r_shift),
      .pop  (w_pop),
      .dout (w_dout),
      .empty(w_empty),
      .full (w_full)
   );

   // Framing-error pulse and sticky overflow (drop only when full with no pop)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= w_stop_bad;
         r_overflow  <= r_overflow | (w_push && w_full && !w_pop);
      end
   end

   assign message   = w_dout;
   assign dataValid = !w_empty;
   assign frameErr  = r_frame_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=8).
// A queue-level model predicts outputs each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_midi_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;
   // rx falls just after edge n; stop bit is sampled on edge n + STOP_EDGE
   localparam int STOP_EDGE = 155;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       rd;
   logic [7:0] message;
   logic       data_valid;
   logic       frame_err;
   logic       overflow;

   midi_uart_rx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .message  (message),
      .dataValid(data_valid),
      .read     (rd),
      .frameErr (frame_err),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         c;
      logic [7:0] b;
      logic       err;
   } ev_t;

   ev_t        evq [$];
   logic [7:0] mq  [$];
   logic [7:0] lit_q [$];
   logic       ovf_m  = 1'b0;
   logic       ferr_m = 1'b0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         ferr_seen = 0;
   int         n0;

   function automatic bit rt_filtered(input logic [7:0] b);
      bit en;
`ifdef MIDI_REALTIME_FILTER_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      return en && (b >= 8'hF8);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   // Model: byte arrives at the stop-sample edge, queue pops on dataValid&&read
   always @(posedge clk) begin
      int  sz;
      bit  do_pop;
      bit  do_push;
      logic [7:0] pb;
      ev_t e;
      cyc = cyc + 1;
      if (!rst) begin
         mq.delete();
         evq.delete();
         ovf_m  = 1'b0;
         ferr_m = 1'b0;
      end else begin
         sz      = mq.size();
         do_pop  = (sz != 0) && rd;
         do_push = 1'b0;
         pb      = 8'h00;
         ferr_m  = 1'b0;
         if (evq.size() != 0 && evq[0].c == cyc) begin
            e = evq.pop_front();
            if (e.err) begin
               ferr_m = 1'b1;
            end else if (!rt_filtered(e.b)) begin
               do_push = 1'b1;
               pb      = e.b;
            end
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            if (sz < DEPTH || do_pop) mq.push_back(pb);
            else ovf_m = 1'b1;
         end
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (frame_err) ferr_seen++;
      if (!rst) begin
         chk("rst_msg", message, 8'h00);
         chk("rst_dv", {7'd0, data_valid}, 8'd0);
         chk("rst_ferr", {7'd0, frame_err}, 8'd0);
         chk("rst_ovf", {7'd0, overflow}, 8'd0);
      end else begin
         chk("m_dv", {7'd0, data_valid}, {7'd0, (mq.size() != 0)});
         chk("m_msg", message, (mq.size() != 0) ? mq[0] : 8'h00);
         chk("m_ferr", {7'd0, frame_err}, {7'd0, ferr_m});
         chk("m_ovf", {7'd0, overflow}, {7'd0, ovf_m});
      end
   end

   // Drive one 8N1 frame; with stop_bit=0 the line is left low
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      ev_t e;
      logic [9:0] bits;
      @(posedge clk);
      #1;
      e.c   = cyc + STOP_EDGE;
      e.b   = b;
      e.err = !stop_bit;
      evq.push_back(e);
      bits = {stop_bit, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         rx = bits[j];
         repeat (CPB) @(posedge clk);
         #1;
      end
      if (stop_bit) rx = 1'b1;
   endtask

   // Raise read and expect lit_q on consecutive cycles, then empty
   task automatic drain_lit(input string nm);
      @(posedge clk);
      #1 rd = 1'b1;
      foreach (lit_q[i]) begin
         @(negedge clk);
         chk({nm, "_dv"}, {7'd0, data_valid}, 8'd1);
         chk({nm, "_msg"}, message, lit_q[i]);
      end
      @(negedge clk);
      chk({nm, "_end_dv"}, {7'd0, data_valid}, 8'd0);
      chk({nm, "_end_msg"}, message, 8'h00);
      @(posedge clk);
      #1 rd = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      rd  = 1'b0;
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("reset_dv", {7'd0, data_valid}, 8'd0);
      chk("reset_msg", message, 8'h00);
      chk("reset_ovf", {7'd0, overflow}, 8'd0);
      repeat (5) @(posedge clk);

      // Single byte with read held high: valid exactly one cycle
      #1 rd = 1'b1;
      fork
         send_frame(8'h90, 1'b1);
         begin
            @(posedge clk);
            #2 n0 = cyc;
            repeat (STOP_EDGE) @(posedge clk);
            @(negedge clk);
            chk("single_dv", {7'd0, data_valid}, 8'd1);
            chk("single_msg", message, 8'h90);
            @(negedge clk);
            chk("single_dv_off", {7'd0, data_valid}, 8'd0);
            chk("single_msg_off", message, 8'h00);
         end
      join
      @(posedge clk);
      #1 rd = 1'b0;

      // Buffering with read low, then burst drain
      send_frame(8'h90, 1'b1);
      send_frame(8'h3C, 1'b1);
      send_frame(8'h64, 1'b1);
      repeat (3) @(negedge clk);
      chk("buf_hold_dv", {7'd0, data_valid}, 8'd1);
      chk("buf_hold_msg", message, 8'h90);
      lit_q = '{8'h90, 8'h3C, 8'h64};
      drain_lit("buf");

      // Framing error with line held low for 40 bit times
      ferr_seen = 0;
      send_frame(8'h00, 1'b0);
      repeat (40 * CPB - 160) @(posedge clk);
      #1 rx = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("break_one_pulse", 8'(ferr_seen), 8'd1);
      chk("break_no_data", {7'd0, data_valid}, 8'd0);
      send_frame(8'h45, 1'b1);
      lit_q = '{8'h45};
      drain_lit("after_break");

      // Start glitch of 4 cycles
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("glitch_no_data", {7'd0, data_valid}, 8'd0);
      chk("glitch_no_ferr", 8'(ferr_seen), 8'd1);

      // Real-time filter
      send_frame(8'h90, 1'b1);
      send_frame(8'hF8, 1'b1);
      send_frame(8'h3C, 1'b1);
`ifdef MIDI_REALTIME_FILTER_EN
      lit_q = '{8'h90, 8'h3C};
`else
      lit_q = '{8'h90, 8'hF8, 8'h3C};
`endif
      drain_lit("filter");

      // Overflow: nine bytes into an eight-deep FIFO
      for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b1);
      @(negedge clk);
      chk("ovf_set", {7'd0, overflow}, 8'd1);
      lit_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      drain_lit("ovf_drain");
      chk("ovf_sticky", {7'd0, overflow}, 8'd1);

      // Reset mid-frame (DATA bit 4) with two bytes buffered
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      @(negedge clk);
      chk("pre_rst_dv", {7'd0, data_valid}, 8'd1);
      chk("pre_rst_msg", message, 8'h11);
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (5 * CPB) @(posedge clk);
      #1 rx = 1'b1;
      repeat (8) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_msg", message, 8'h00);
      chk("midrst_dv", {7'd0, data_valid}, 8'd0);
      chk("midrst_ferr", {7'd0, frame_err}, 8'd0);
      chk("midrst_ovf", {7'd0, overflow}, 8'd0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      repeat (100) @(posedge clk);
      send_frame(8'h7F, 1'b1);
      @(negedge clk);
      chk("post_rst_ovf", {7'd0, overflow}, 8'd0);
      lit_q = '{8'h7F};
      drain_lit("post_rst");

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
